// File: rtl/simplecpu_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : simplecpu_ctrl
// Brief   : Multi-cycle fetch/decode/execute/mem sequencer for simplecpu.
// Revision: 1.0
// ============================================================================
module simplecpu_ctrl #(
  parameter int PC_W        = 10,
  parameter int DADDR_W     = 8,
  parameter int RESET_PC    = 0,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [15:0]        i_imem_rdata,
  input  logic               i_imem_ack,
  input  logic               i_dmem_ack,
  input  logic               i_rd1_zero,
  output logic [PC_W-1:0]    o_pc,
  output logic               o_imem_ren,
  output logic               o_dmem_ren,
  output logic               o_dmem_wen,
  output logic [DADDR_W-1:0] o_dmem_addr,
  output logic [3:0]         o_rf_ra1,
  output logic [3:0]         o_rf_ra2,
  output logic [3:0]         o_rf_wa,
  output logic               o_rf_we,
  output logic [1:0]         o_wb_sel,
  output logic [1:0]         o_alu_op,
  output logic [15:0]        o_retired,
  output logic               o_halted,
  output logic               o_illegal,
  output logic               o_bus_err
);

  localparam int c_WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [c_WAIT_W-1:0] c_WAIT_MAX = c_WAIT_W'(MEM_TIMEOUT);
  localparam logic [PC_W-1:0]     c_RESET_PC = PC_W'(RESET_PC);

  localparam logic [3:0] c_OP_LOAD  = 4'h0;
  localparam logic [3:0] c_OP_STORE = 4'h1;
  localparam logic [3:0] c_OP_ADD   = 4'h2;
  localparam logic [3:0] c_OP_SUB   = 4'h3;
  localparam logic [3:0] c_OP_AND   = 4'h4;
  localparam logic [3:0] c_OP_OR    = 4'h5;
  localparam logic [3:0] c_OP_LDI   = 4'h6;
  localparam logic [3:0] c_OP_JMP   = 4'h8;
  localparam logic [3:0] c_OP_BEQZ  = 4'h9;
  localparam logic [3:0] c_OP_HALT  = 4'hF;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  state_t              r_state;
  logic [PC_W-1:0]     r_pc;
  logic [15:0]         r_ir;
  logic [c_WAIT_W-1:0] r_wait;
  logic [15:0]         r_retired;
  logic                r_illegal;
  logic                r_bus_err;

  logic [3:0]      w_op;
  logic            w_is_load;
  logic            w_is_store;
  logic            w_is_alu;
  logic            w_is_ldi;
  logic            w_is_jmp;
  logic            w_is_beqz;
  logic            w_is_halt;
  logic            w_is_illegal;
  logic            w_wait_expired;
  logic [PC_W-1:0] w_pc_inc;
  logic [PC_W-1:0] w_pc_a8;

  assign w_op       = r_ir[15:12];
  assign w_is_load  = (w_op == c_OP_LOAD);
  assign w_is_store = (w_op == c_OP_STORE);
  assign w_is_alu   = (w_op == c_OP_ADD) || (w_op == c_OP_SUB) ||
                      (w_op == c_OP_AND) || (w_op == c_OP_OR);
  assign w_is_ldi   = (w_op == c_OP_LDI);
  assign w_is_jmp   = (w_op == c_OP_JMP);
  assign w_is_beqz  = (w_op == c_OP_BEQZ);
  assign w_is_halt  = (w_op == c_OP_HALT);
  assign w_is_illegal = !(w_is_load || w_is_store || w_is_alu || w_is_ldi ||
                          w_is_jmp || w_is_beqz || w_is_halt);

  assign w_wait_expired = (r_wait == c_WAIT_MAX);
  assign w_pc_inc       = r_pc + PC_W'(1);
  assign w_pc_a8        = PC_W'(r_ir[7:0]);

  // Strobes decode the registered state; rst masks them so a reset cycle,
  // even one landing mid-handshake, never presents a request.
  assign o_imem_ren = !rst && (r_state == S_FETCH);
  assign o_dmem_ren = !rst && (r_state == S_MEM) && w_is_load;
  assign o_dmem_wen = !rst && (r_state == S_MEM) && w_is_store;
  assign o_rf_we    = !rst && (((r_state == S_EXEC) && (w_is_alu || w_is_ldi)) ||
                               ((r_state == S_MEM) && w_is_load && i_dmem_ack));

  assign o_wb_sel    = w_is_load ? 2'b01 : (w_is_ldi ? 2'b10 : 2'b00);
  // ADD/SUB/AND/OR are opcodes 2..5; flipping bit 1 maps them onto 0..3.
  assign o_alu_op    = w_op[1:0] ^ 2'b10;
  assign o_rf_ra1    = (w_is_store || w_is_beqz) ? r_ir[11:8] : r_ir[7:4];
  assign o_rf_ra2    = r_ir[3:0];
  assign o_rf_wa     = r_ir[11:8];
  assign o_dmem_addr = r_ir[DADDR_W-1:0];
  assign o_pc        = r_pc;
  assign o_retired   = r_retired;
  assign o_halted    = (r_state == S_HALT);
  assign o_illegal   = r_illegal;
  assign o_bus_err   = r_bus_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_pc      <= c_RESET_PC;
      r_ir      <= '0;
      r_wait    <= '0;
      r_retired <= '0;
      r_illegal <= 1'b0;
      r_bus_err <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (i_imem_ack) begin
            r_ir    <= i_imem_rdata;
            r_state <= S_DECODE;
          end else if (w_wait_expired) begin
            r_bus_err <= 1'b1;
            r_state   <= S_HALT;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        S_DECODE: begin
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_wait <= '0;
          if (w_is_load || w_is_store) begin
            r_state <= S_MEM;
          end else if (w_is_halt) begin
            r_state <= S_HALT;
          end else begin
            r_state   <= S_FETCH;
            r_retired <= r_retired + 16'd1;
            if (w_is_jmp || (w_is_beqz && i_rd1_zero)) begin
              r_pc <= w_pc_a8;
            end else begin
              r_pc <= w_pc_inc;
            end
            if (w_is_illegal) begin
              r_illegal <= 1'b1;
            end
          end
        end
        S_MEM: begin
          if (i_dmem_ack) begin
            r_pc      <= w_pc_inc;
            r_retired <= r_retired + 16'd1;
            r_wait    <= '0;
            r_state   <= S_FETCH;
          end else if (w_wait_expired) begin
            r_bus_err <= 1'b1;
            r_state   <= S_HALT;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        S_HALT: begin
          r_state <= S_HALT;
        end
        default: begin
          r_state <= S_HALT;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_simplecpu_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_simplecpu_ctrl
// Brief   : Scoreboard bench for simplecpu_ctrl driven by an ISA-level model.
// Revision: 1.0
// ============================================================================
module tb_simplecpu_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] i_imem_rdata = '0;
  logic        i_imem_ack = 1'b0;
  logic        i_dmem_ack = 1'b0;
  logic        i_rd1_zero = 1'b0;
  logic [9:0]  o_pc;
  logic        o_imem_ren, o_dmem_ren, o_dmem_wen, o_rf_we;
  logic [7:0]  o_dmem_addr;
  logic [3:0]  o_rf_ra1, o_rf_ra2, o_rf_wa;
  logic [1:0]  o_wb_sel, o_alu_op;
  logic [15:0] o_retired;
  logic        o_halted, o_illegal, o_bus_err;

  always #5 clk = ~clk;

  simplecpu_ctrl #(.PC_W(10), .DADDR_W(8), .RESET_PC(0), .MEM_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .i_imem_rdata(i_imem_rdata), .i_imem_ack(i_imem_ack),
    .i_dmem_ack(i_dmem_ack), .i_rd1_zero(i_rd1_zero),
    .o_pc(o_pc), .o_imem_ren(o_imem_ren), .o_dmem_ren(o_dmem_ren),
    .o_dmem_wen(o_dmem_wen), .o_dmem_addr(o_dmem_addr),
    .o_rf_ra1(o_rf_ra1), .o_rf_ra2(o_rf_ra2), .o_rf_wa(o_rf_wa),
    .o_rf_we(o_rf_we), .o_wb_sel(o_wb_sel), .o_alu_op(o_alu_op),
    .o_retired(o_retired), .o_halted(o_halted), .o_illegal(o_illegal),
    .o_bus_err(o_bus_err)
  );

  // kind 0 = fetch handshake, 1 = register write, 2 = data-memory handshake
  typedef struct { int kind; int a; int b; int c; int d; } exp_t;
  typedef struct { logic [15:0] instr; logic rz; } prog_t;

  exp_t  exp_q[$];
  prog_t prog_q[$];
  int    checks = 0;
  int    errors = 0;
  int    m_pc = 0, m_ret = 0, m_ill = 0;
  int    imem_fix = -1, dmem_fix = -1, lat_max = 0;
  bit    imem_never = 0, dmem_never = 0, mon_en = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push_exp(input int k, input int a, input int b, input int c, input int d);
    exp_t e;
    e.kind = k; e.a = a; e.b = b; e.c = c; e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic push_prog(input logic [15:0] ins, input logic rz);
    prog_t p;
    p.instr = ins; p.rz = rz;
    prog_q.push_back(p);
  endtask

  // ISA-level reference: what each instruction must make the sequencer do.
  task automatic model_instr(input logic [15:0] ins, input logic rz);
    int op, rd, rs1, a8;
    op = int'(ins[15:12]); rd = int'(ins[11:8]); rs1 = int'(ins[7:4]); a8 = int'(ins[7:0]);
    push_prog(ins, rz);
    push_exp(0, m_pc, m_ret, m_ill, 0);
    case (op)
      0: begin push_exp(2, 0, a8, -1, 0); push_exp(1, rd, 1, -1, -1); end
      1: push_exp(2, 1, a8, rd, 0);
      2, 3, 4, 5: push_exp(1, rd, 0, op - 2, rs1);
      6: push_exp(1, rd, 2, -1, -1);
      default: ;
    endcase
    if (op != 15) begin
      if (op == 8 || (op == 9 && rz)) m_pc = a8;
      else m_pc = (m_pc + 1) % 1024;
      m_ret = (m_ret + 1) % 65536;
      if (op == 7 || (op >= 10 && op <= 14)) m_ill = 1;
    end
  endtask

  function automatic int pick_lat(input int fix, input bit never);
    if (never) return 1000000;
    if (fix >= 0) return fix;
    return int'($urandom_range(0, lat_max));
  endfunction

  // Memory responder: acknowledges requests after a chosen latency.
  initial begin
    int icnt, dcnt;
    bit ibusy, dbusy;
    prog_t p;
    icnt = 0; dcnt = 0; ibusy = 0; dbusy = 0;
    forever begin
      @(posedge clk); #2;
      if (rst) begin
        ibusy = 0; dbusy = 0; i_imem_ack = 1'b0; i_dmem_ack = 1'b0;
      end else begin
        if (i_imem_ack) begin i_imem_ack = 1'b0; ibusy = 0; end
        if (i_dmem_ack) begin i_dmem_ack = 1'b0; dbusy = 0; end
        if (!o_imem_ren) ibusy = 0;
        if (!(o_dmem_ren || o_dmem_wen)) dbusy = 0;
        if (o_imem_ren && !ibusy) begin ibusy = 1; icnt = pick_lat(imem_fix, imem_never); end
        if (ibusy) begin
          if (icnt == 0) begin
            if (prog_q.size() > 0) begin
              p = prog_q.pop_front();
              i_imem_rdata = p.instr; i_rd1_zero = p.rz; i_imem_ack = 1'b1;
            end
          end else icnt--;
        end
        if ((o_dmem_ren || o_dmem_wen) && !dbusy) begin dbusy = 1; dcnt = pick_lat(dmem_fix, dmem_never); end
        if (dbusy) begin
          if (dcnt == 0) i_dmem_ack = 1'b1;
          else dcnt--;
        end
      end
    end
  end

  task automatic pop_exp(input int kind, output exp_t e, output bit ok);
    checks++;
    ok = 0;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: unexpected event kind %0d, none required (t=%0t)", kind, $time);
    end else begin
      e = exp_q.pop_front(); ok = 1;
      chk("event_kind", kind, e.kind);
    end
  endtask

  // Monitor: compares every observed handshake/write against the scoreboard.
  initial begin
    exp_t e;
    bit ok;
    forever begin
      @(negedge clk);
      if (mon_en && !rst) begin
        chk("strobe_onehot", int'($countones({o_imem_ren, o_dmem_ren, o_dmem_wen}) <= 1), 1);
        if (o_imem_ren && i_imem_ack) begin
          pop_exp(0, e, ok);
          if (ok && e.kind == 0) begin
            chk("fetch_pc", int'(o_pc), e.a);
            chk("fetch_retired", int'(o_retired), e.b);
            chk("fetch_illegal", int'(o_illegal), e.c);
          end
        end
        if ((o_dmem_ren || o_dmem_wen) && i_dmem_ack) begin
          pop_exp(2, e, ok);
          if (ok && e.kind == 2) begin
            chk("dmem_wen", int'(o_dmem_wen), e.a);
            chk("dmem_addr", int'(o_dmem_addr), e.b);
            if (e.c >= 0) chk("dmem_ra1", int'(o_rf_ra1), e.c);
          end
        end
        if (o_rf_we) begin
          pop_exp(1, e, ok);
          if (ok && e.kind == 1) begin
            chk("rf_wa", int'(o_rf_wa), e.a);
            chk("wb_sel", int'(o_wb_sel), e.b);
            if (e.c >= 0) chk("alu_op", int'(o_alu_op), e.c);
            if (e.d >= 0) chk("rf_ra1", int'(o_rf_ra1), e.d);
          end
        end
      end
    end
  end

  task automatic do_reset(input int n);
    mon_en = 0;
    @(posedge clk); #1 rst = 1'b1;
    repeat (n) @(posedge clk);
    exp_q.delete(); prog_q.delete();
    m_pc = 0; m_ret = 0; m_ill = 0;
    #1 rst = 1'b0; mon_en = 1;
  endtask

  task automatic wait_halt(input int limit);
    int n;
    n = 0;
    while (!o_halted && n < limit) begin @(negedge clk); n++; end
    chk("halted_within_budget", int'(o_halted), 1);
  endtask

  task automatic end_phase(input int limit);
    wait_halt(limit);
    chk("final_pc", int'(o_pc), m_pc);
    chk("final_retired", int'(o_retired), m_ret);
    chk("final_illegal", int'(o_illegal), m_ill);
    chk("final_bus_err", int'(o_bus_err), 0);
    chk("scoreboard_drained", exp_q.size(), 0);
  endtask

  task automatic gen_random(input int n, input bit alu_only);
    logic [15:0] ins;
    int r;
    for (int i = 0; i < n; i++) begin
      r = alu_only ? int'($urandom_range(2, 6)) : int'($urandom_range(0, 19));
      if (r >= 15) r = r - 13;
      ins = $urandom();
      ins[15:12] = 4'(r);
      model_instr(ins, 1'($urandom_range(0, 1)));
    end
    model_instr(16'hF000, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, cnt2, bad;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_strobes", int'({o_imem_ren, o_dmem_ren, o_dmem_wen, o_rf_we}), 0);

    // Straight-line ALU program, zero-wait memories.
    do_reset(2);
    model_instr(16'h6105, 1'b0); model_instr(16'h6203, 1'b0);
    model_instr(16'h2312, 1'b0); model_instr(16'hF000, 1'b0);
    @(negedge clk);
    chk("reset_pc", int'(o_pc), 0);
    chk("reset_retired", int'(o_retired), 0);
    chk("reset_flags", int'({o_halted, o_illegal, o_bus_err}), 0);
    chk("first_fetch_req", int'(o_imem_ren), 1);
    repeat (9) @(posedge clk);
    @(negedge clk);
    chk("prog_pc_after_9", int'(o_pc), 3);
    chk("prog_retired_after_9", int'(o_retired), 3);
    end_phase(50);
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (o_pc != 10'(m_pc) || o_imem_ren || o_dmem_ren || o_dmem_wen || o_rf_we || !o_halted) bad++;
    end
    chk("halt_frozen_bad_cycles", bad, 0);

    // LOAD with four wait cycles.
    do_reset(2);
    dmem_fix = 4;
    model_instr(16'h0440, 1'b0); model_instr(16'hF000, 1'b0);
    cnt = 0; cnt2 = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (o_dmem_ren) cnt++;
      if (o_rf_we) cnt2++;
    end
    chk("load_dmem_ren_cycles", cnt, 5);
    chk("load_rf_we_cycles", cnt2, 1);
    end_phase(50);
    dmem_fix = -1;

    // BEQZ taken then not taken.
    do_reset(2);
    model_instr(16'h9120, 1'b1); model_instr(16'h9120, 1'b0); model_instr(16'hF000, 1'b0);
    end_phase(50);
    chk("beqz_final_pc", int'(o_pc), 10'h021);

    // Illegal opcode is sticky and acts as a NOP.
    do_reset(2);
    model_instr(16'hA000, 1'b0); model_instr(16'h6105, 1'b0);
    model_instr(16'hC3FF, 1'b0); model_instr(16'hF000, 1'b0);
    end_phase(60);
    chk("illegal_sticky", int'(o_illegal), 1);

    // Instruction memory never answers.
    do_reset(2);
    imem_never = 1;
    cnt = 0;
    for (int i = 0; i < 100 && !o_halted; i++) begin
      @(negedge clk);
      if (o_imem_ren) cnt++;
    end
    chk("timeout_fetch_cycles", cnt, 16);
    chk("timeout_bus_err", int'(o_bus_err), 1);
    chk("timeout_halted", int'(o_halted), 1);
    chk("timeout_retired", int'(o_retired), 0);
    imem_never = 0;

    // Acks on the last permitted cycle still complete.
    do_reset(2);
    imem_fix = 15; dmem_fix = 15;
    model_instr(16'h1233, 1'b0); model_instr(16'h0512, 1'b0); model_instr(16'hF000, 1'b0);
    end_phase(300);
    imem_fix = -1; dmem_fix = -1;

    // Data memory never answers: aborted LOAD does not retire.
    do_reset(2);
    dmem_never = 1;
    model_instr(16'h6105, 1'b0);
    push_prog(16'h0440, 1'b0);
    push_exp(0, m_pc, m_ret, m_ill, 0);
    wait_halt(100);
    chk("dmem_timeout_bus_err", int'(o_bus_err), 1);
    chk("dmem_timeout_retired", int'(o_retired), 1);
    chk("dmem_timeout_pc", int'(o_pc), 1);
    chk("dmem_timeout_drained", exp_q.size(), 0);

    // Reset in the middle of a data-memory wait.
    do_reset(2);
    model_instr(16'hA000, 1'b0);
    push_prog(16'h0440, 1'b0);
    push_exp(0, m_pc, m_ret, m_ill, 0);
    cnt = 0;
    while (!o_dmem_ren && cnt < 50) begin @(negedge clk); cnt++; end
    chk("mem_wait_reached", int'(o_dmem_ren), 1);
    repeat (3) @(negedge clk);
    chk("pre_reset_illegal", int'(o_illegal), 1);
    @(posedge clk); #1 rst = 1'b1; mon_en = 0;
    @(negedge clk);
    chk("rst_strobes_immediate", int'({o_imem_ren, o_dmem_ren, o_dmem_wen, o_rf_we}), 0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_pc", int'(o_pc), 0);
    chk("rst_mid_strobes", int'({o_imem_ren, o_dmem_ren, o_dmem_wen, o_rf_we}), 0);
    chk("rst_mid_flags", int'({o_halted, o_illegal, o_bus_err}), 0);
    chk("rst_mid_retired", int'(o_retired), 0);
    dmem_never = 0;

    // Random programs with random memory latency.
    lat_max = 3;
    for (int run = 0; run < 6; run++) begin
      do_reset(2);
      gen_random(40, 1'b0);
      end_phase(3000);
    end

    // Long zero-wait run so the PC wraps past 1023.
    lat_max = 0;
    do_reset(2);
    gen_random(1030, 1'b1);
    end_phase(5000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
